// File: rtl/traffic_light_fsm.sv
// Traffic light controller: main road, side road and pedestrian phases.
// Each phase is timed in OneHz ticks; outputs are registered.
module traffic_light_fsm #(
    parameter int unsigned T_MG = 10,
    parameter int unsigned T_MY = 3,
    parameter int unsigned T_AR = 1,
    parameter int unsigned T_SG = 6,
    parameter int unsigned T_SY = 3,
    parameter int unsigned T_PW = 5
) (
    input  logic       clk,
    input  logic       Sync_Reset,
    input  logic       OneHz,
    input  logic       side_car,
    input  logic       ped_btn,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic [7:0] sec_left,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        MG  = 3'd0,
        MY  = 3'd1,
        AR1 = 3'd2,
        SG  = 3'd3,
        SY  = 3'd4,
        AR2 = 3'd5,
        PW  = 3'd6
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    state_t     cur;
    state_t     nxt;
    logic       hz_d;
    logic       tick;
    logic       expired;
    logic       enter;
    logic [7:0] timer;
    logic [7:0] timer_n;
    logic       side_req;
    logic       side_req_n;
    logic       ped_req;
    logic       ped_req_n;
    logic [2:0] main_n;
    logic [2:0] side_n;
    logic       walk_n;

    function automatic logic [7:0] dur(input state_t s);
        case (s)
            MG:      dur = 8'(T_MG);
            MY:      dur = 8'(T_MY);
            AR1:     dur = 8'(T_AR);
            SG:      dur = 8'(T_SG);
            SY:      dur = 8'(T_SY);
            AR2:     dur = 8'(T_AR);
            PW:      dur = 8'(T_PW);
            default: dur = 8'(T_MG);
        endcase
    endfunction

    assign tick    = OneHz & ~hz_d;
    assign expired = tick & (timer == 8'd1);

    // Next state, timer, request latches and next light pattern.
    always_comb begin
        nxt     = cur;
        timer_n = timer;
        main_n  = RED;
        side_n  = RED;
        walk_n  = 1'b0;
        case (cur)
            MG:  if (expired && (side_req || ped_req)) nxt = MY;
            MY:  if (expired) nxt = AR1;
            AR1: if (expired) nxt = side_req ? SG : PW;
            SG:  if (expired) nxt = SY;
            SY:  if (expired) nxt = AR2;
            AR2: if (expired) nxt = ped_req ? PW : MG;
            PW:  if (expired) nxt = MG;
            default: nxt = MG;
        endcase
        enter = (nxt != cur);
        if (enter) begin
            timer_n = dur(nxt);
        end else if (tick && timer > 8'd1) begin
            timer_n = timer - 8'd1;
        end
        side_req_n = (side_req | side_car) & ~(enter && nxt == SG);
        ped_req_n  = (ped_req | ped_btn) & ~(enter && nxt == PW);
        case (nxt)
            MG:      main_n = GRN;
            MY:      main_n = YEL;
            SG:      side_n = GRN;
            SY:      side_n = YEL;
            PW:      walk_n = 1'b1;
            default: main_n = RED;
        endcase
    end

    // State, timer, requests and registered lamp outputs.
    always_ff @(posedge clk or posedge Sync_Reset) begin
        if (Sync_Reset) begin
            cur        <= MG;
            timer      <= 8'(T_MG);
            hz_d       <= 1'b0;
            side_req   <= 1'b0;
            ped_req    <= 1'b0;
            main_light <= GRN;
            side_light <= RED;
            walk       <= 1'b0;
        end else begin
            cur        <= nxt;
            timer      <= timer_n;
            hz_d       <= OneHz;
            side_req   <= side_req_n;
            ped_req    <= ped_req_n;
            main_light <= main_n;
            side_light <= side_n;
            walk       <= walk_n;
        end
    end

    assign sec_left = timer;
    assign state    = cur;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm: directed scenarios plus random traffic,
// checked every cycle against a table-driven phase model.
module tb_traffic_light_fsm;

    localparam int D_MG = 10;
    localparam int D_MY = 3;
    localparam int D_AR = 1;
    localparam int D_SG = 6;
    localparam int D_SY = 3;
    localparam int D_PW = 5;

    logic       clk = 0;
    logic       rst = 1;
    logic       OneHz = 0;
    logic       side_car = 0;
    logic       ped_btn = 0;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
    logic [7:0] sec_left;
    logic [2:0] state;

    int total = 0;
    int bad = 0;

    traffic_light_fsm dut (
        .clk(clk),
        .Sync_Reset(rst),
        .OneHz(OneHz),
        .side_car(side_car),
        .ped_btn(ped_btn),
        .main_light(main_light),
        .side_light(side_light),
        .walk(walk),
        .sec_left(sec_left),
        .state(state)
    );

    always #5 clk = ~clk;

    // Phase tables, index = phase number 0..6.
    int dur[7] = '{D_MG, D_MY, D_AR, D_SG, D_SY, D_AR, D_PW};
    logic [2:0] main_tab[7] = '{3'b001, 3'b010, 3'b100, 3'b100,
                                3'b100, 3'b100, 3'b100};
    logic [2:0] side_tab[7] = '{3'b100, 3'b100, 3'b100, 3'b001,
                                3'b010, 3'b100, 3'b100};

    int m_st;
    int m_tm;
    bit m_sr;
    bit m_pr;
    bit m_hz;

    // Which phase follows st when its time runs out.
    function automatic int follow(input int st, input bit sr, input bit pr);
        case (st)
            0: return (sr || pr) ? 1 : 0;
            1: return 2;
            2: return sr ? 3 : 6;
            3: return 4;
            4: return 5;
            5: return pr ? 6 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic bit ends(input int tm, input bit hz_now, input bit hz_old);
        return hz_now && !hz_old && tm == 1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st <= 0;
            m_tm <= D_MG;
            m_sr <= 0;
            m_pr <= 0;
            m_hz <= 0;
        end else begin
            m_hz <= OneHz;
            if (ends(m_tm, OneHz, m_hz) && follow(m_st, m_sr, m_pr) != m_st) begin
                m_st <= follow(m_st, m_sr, m_pr);
                m_tm <= dur[follow(m_st, m_sr, m_pr)];
            end else if (OneHz && !m_hz && m_tm > 1) begin
                m_tm <= m_tm - 1;
            end
            if (ends(m_tm, OneHz, m_hz) && m_st == 2 && m_sr)
                m_sr <= 0;
            else
                m_sr <= m_sr | side_car;
            if (ends(m_tm, OneHz, m_hz) && ((m_st == 2 && !m_sr) ||
                                            (m_st == 5 && m_pr)))
                m_pr <= 0;
            else
                m_pr <= m_pr | ped_btn;
        end
    end

    // Per-cycle comparison against the model, plus lamp sanity.
    always @(negedge clk) begin
        total++;
        if (main_light !== main_tab[m_st] || side_light !== side_tab[m_st] ||
            walk !== (m_st == 6) || sec_left !== 8'(m_tm) ||
            state !== 3'(m_st)) begin
            bad++;
            $display("FAIL cycle t=%0t got st=%0d sec=%0d m=%b s=%b w=%b exp st=%0d sec=%0d m=%b s=%b w=%b",
                     $time, state, sec_left, main_light, side_light, walk,
                     m_st, m_tm, main_tab[m_st], side_tab[m_st], m_st == 6);
        end
        total++;
        if (!$onehot(main_light) || !$onehot(side_light) ||
            !(main_light[2] || side_light[2])) begin
            bad++;
            $display("FAIL lamps t=%0t got m=%b s=%b need one-hot, one red",
                     $time, main_light, side_light);
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            OneHz = 1;
            @(negedge clk);
            OneHz = 0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        OneHz = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    task automatic pulse_side();
        side_car = 1;
        @(negedge clk);
        side_car = 0;
    endtask

    task automatic pulse_ped();
        ped_btn = 1;
        @(negedge clk);
        ped_btn = 0;
    endtask

    int cnt;

    initial begin
        @(negedge clk);
        do_reset();
        chk("rst_state", state, 0);
        chk("rst_sec", sec_left, 10);
        chk("rst_main", main_light, 3'b001);
        chk("rst_side", side_light, 3'b100);

        // Idle main road: count down then hold at 1.
        ticks(9);
        chk("idle9_sec", sec_left, 1);
        ticks(6);
        chk("idle15_st", state, 0);
        chk("idle15_sec", sec_left, 1);
        chk("idle15_main", main_light, 3'b001);

        // Side car during MG.
        do_reset();
        ticks(2);
        pulse_side();
        ticks(7);
        chk("side_mg9", state, 0);
        ticks(1);
        chk("side_my", state, 1);
        chk("side_my_sec", sec_left, 3);
        chk("side_my_main", main_light, 3'b010);
        ticks(3);
        chk("side_ar1", state, 2);
        ticks(1);
        chk("side_sg", state, 3);
        chk("side_sg_sec", sec_left, 6);
        chk("side_sg_side", side_light, 3'b001);
        chk("side_sg_main", main_light, 3'b100);
        ticks(6);
        chk("side_sy", state, 4);
        ticks(3);
        chk("side_ar2", state, 5);
        ticks(1);
        chk("side_back", state, 0);
        chk("side_back_sec", sec_left, 10);
        ticks(12);
        chk("side_req_clr", state, 0);

        // Pedestrian only.
        do_reset();
        ticks(4);
        pulse_ped();
        ticks(6);
        chk("ped_my", state, 1);
        ticks(4);
        chk("ped_pw", state, 6);
        chk("ped_walk", walk, 1);
        chk("ped_pw_sec", sec_left, 5);
        ticks(4);
        chk("ped_walk4", walk, 1);
        ticks(1);
        chk("ped_mg", state, 0);
        chk("ped_walk_off", walk, 0);
        ticks(12);
        chk("ped_req_clr", state, 0);

        // Both requests: side phase then walk.
        do_reset();
        pulse_side();
        pulse_ped();
        ticks(14);
        chk("both_sg", state, 3);
        ticks(9);
        chk("both_ar2", state, 5);
        ticks(1);
        chk("both_pw", state, 6);
        ticks(5);
        chk("both_mg", state, 0);

        // Reset in the middle of SG.
        do_reset();
        pulse_side();
        ticks(16);
        chk("mid_sg_sec", sec_left, 4);
        #2 rst = 1;
        #1;
        chk("async_st", state, 0);
        chk("async_main", main_light, 3'b001);
        chk("async_side", side_light, 3'b100);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        ticks(12);
        chk("async_noreq", state, 0);

        // OneHz high at release, then held: one tick only.
        rst = 1;
        OneHz = 1;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("first_clk_tick", sec_left, 9);
        repeat (1000) @(negedge clk);
        chk("held_hz", sec_left, 9);
        OneHz = 0;

        // Random traffic.
        do_reset();
        cnt = 0;
        for (int i = 0; i < 6000; i++) begin
            side_car = ($urandom_range(0, 59) == 0);
            ped_btn = ($urandom_range(0, 79) == 0);
            if (cnt == 0) begin
                OneHz = ~OneHz;
                cnt = $urandom_range(0, 3);
            end else begin
                cnt--;
            end
            rst = ($urandom_range(0, 1999) == 0);
            @(negedge clk);
        end
        rst = 0;
        side_car = 0;
        ped_btn = 0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
